// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a byte-wide data memory. Halfword requests are
// split into two little-endian byte accesses; read data is assembled into a held response.
module mem_access_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_wide,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  resp_valid,
  output logic [2*DATA_W-1:0]   resp_rdata,
  output logic                  resp_wrap,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic                  wide_q,  wide_d;
  logic [ADDR_W-1:0]     addr_q,  addr_d;
  logic [2*DATA_W-1:0]   wdata_q, wdata_d;
  logic [2*DATA_W-1:0]   rdata_q, rdata_d;
  logic                  wrap_q,  wrap_d;

  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      wide_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      wide_q  <= wide_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wrap_q  <= wrap_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    wide_d  = wide_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wrap_d  = wrap_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          wide_d  = req_wide;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          wrap_d  = 1'b0;
          state_d = BYTE0;
        end
      end
      BYTE0: begin
        if (!write_q) begin
          rdata_d[DATA_W-1:0] = mem_rdata;
        end
        state_d = wide_q ? BYTE1 : RESP;
      end
      BYTE1: begin
        if (!write_q) begin
          rdata_d[2*DATA_W-1:DATA_W] = mem_rdata;
        end
        wrap_d  = (addr_q == LAST_ADDR);
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory pins depend only on state and latched request; enables are also
  // gated by reset so nothing is written on a reset edge mid-operation.
  always_comb begin
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_wdata        = '0;

    unique case (state_q)
      BYTE0: begin
        mem_read_enable  = ~write_q & reset_n;
        mem_write_enable = write_q & reset_n;
        mem_address      = addr_q;
        mem_wdata        = wdata_q[DATA_W-1:0];
      end
      BYTE1: begin
        mem_read_enable  = ~write_q & reset_n;
        mem_write_enable = write_q & reset_n;
        mem_address      = addr_q + ADDR_W'(1);
        mem_wdata        = wdata_q[2*DATA_W-1:DATA_W];
      end
      default: begin
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
      end
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_wrap  = wrap_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a byte-array memory sits on the mem_* pins
// and a request-level reference model predicts bus activity, latency and responses.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_wide;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_wrap;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [7:0]  mem_address;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic        init_we;
  logic [7:0]  init_addr;
  logic [7:0]  init_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_wide         (req_wide),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_wrap        (resp_wrap),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata)
  );

  // Data memory: combinational read, write on the clock edge.
  assign mem_rdata = mem_read_enable ? mem[mem_address] : 8'h00;

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address] <= mem_wdata;
    else if (init_we)     mem[init_addr]   <= init_data;
  end

  // One complete request from the reference model's point of view. Called at a
  // negedge with the unit idle; returns at the negedge of the idle cycle after RESP.
  // With hold set, req_valid stays high and the other req_* fields churn while busy.
  task automatic run_req(input logic wr, input logic wd, input logic [7:0] a,
                         input logic [15:0] wdat, input bit hold);
    int          nb;
    logic [15:0] exp_rdata;
    logic        exp_wrap;
    logic [19:0] exp_bus;
    logic [19:0] obs_bus;
    logic [7:0]  byte_addr;
    nb        = wd ? 2 : 1;
    exp_wrap  = wd && (a == 8'hFF);
    exp_rdata = 16'h0000;
    if (!wr) begin
      exp_rdata[7:0] = ref_mem[a];
      if (wd) exp_rdata[15:8] = ref_mem[8'(a + 8'd1)];
    end else begin
      ref_mem[a] = wdat[7:0];
      if (wd) ref_mem[8'(a + 8'd1)] = wdat[15:8];
    end

    req_valid = 1'b1;
    req_write = wr;
    req_wide  = wd;
    req_addr  = a;
    req_wdata = wdat;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_ready: got %b expected 1 (addr %02h)", req_ready, a);
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;

    for (int k = 1; k <= nb + 2; k++) begin
      @(negedge clk);
      if (hold) begin
        req_write = 1'($urandom);
        req_wide  = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = 16'($urandom);
      end
      if (k <= nb) begin
        byte_addr = 8'(a + 8'(k - 1));
        exp_bus = {!wr, wr, byte_addr, (k == 1) ? wdat[7:0] : wdat[15:8], 1'b0, 1'b0};
      end else if (k == nb + 1) begin
        exp_bus = {2'b00, 8'h00, 8'h00, 1'b1, 1'b0};
      end else begin
        exp_bus = {2'b00, 8'h00, 8'h00, 1'b0, 1'b1};
      end
      obs_bus = {mem_read_enable, mem_write_enable, mem_address, mem_wdata, resp_valid, req_ready};
      vectors++;
      if (obs_bus !== exp_bus) begin
        miscompares++;
        $display("FAIL bus_cycle%0d: {re,we,addr,wdata,rvalid,ready} got %05h expected %05h (wr=%b wide=%b addr=%02h)",
                 k, obs_bus, exp_bus, wr, wd, a);
      end
      if (k == nb + 1) begin
        vectors++;
        if ({resp_rdata, resp_wrap} !== {exp_rdata, exp_wrap}) begin
          miscompares++;
          $display("FAIL response: rdata/wrap got %04h/%b expected %04h/%b (wr=%b wide=%b addr=%02h)",
                   resp_rdata, resp_wrap, exp_rdata, exp_wrap, wr, wd, a);
        end
      end else if (k == nb + 2) begin
        vectors++;
        if (resp_rdata !== exp_rdata) begin
          miscompares++;
          $display("FAIL rdata_hold: got %04h expected %04h", resp_rdata, exp_rdata);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({mem_read_enable, mem_write_enable} !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_enables: got %b%b expected 00", mem_read_enable, mem_write_enable);
      end
    end
    reset_n = 1'b1;
    #1;
    vectors++;
    if ({req_ready, resp_valid, resp_rdata, resp_wrap, mem_read_enable, mem_write_enable,
         mem_address, mem_wdata} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b rvalid=%b rdata=%04h wrap=%b re=%b we=%b addr=%02h wdata=%02h",
               req_ready, resp_valid, resp_rdata, resp_wrap, mem_read_enable, mem_write_enable,
               mem_address, mem_wdata);
    end
  endtask

  task automatic check_mem(input string name, input logic [7:0] a, input logic [7:0] expected);
    vectors++;
    if (mem[a] !== expected) begin
      miscompares++;
      $display("FAIL %s: memory[%02h] got %02h expected %02h", name, a, mem[a], expected);
    end
  endtask

  task automatic test_byte();
    run_req(1'b1, 1'b0, 8'h10, 16'h00A5, 1'b0);
    check_mem("byte_store", 8'h10, 8'hA5);
    run_req(1'b0, 1'b0, 8'h10, 16'h0000, 1'b0);
  endtask

  task automatic test_halfword();
    run_req(1'b1, 1'b1, 8'h40, 16'hBEEF, 1'b0);
    check_mem("half_store_lo", 8'h40, 8'hEF);
    check_mem("half_store_hi", 8'h41, 8'hBE);
    run_req(1'b0, 1'b1, 8'h40, 16'h0000, 1'b0);
  endtask

  task automatic test_wrap();
    run_req(1'b1, 1'b1, 8'hFF, 16'h1234, 1'b0);
    check_mem("wrap_store_lo", 8'hFF, 8'h34);
    check_mem("wrap_store_hi", 8'h00, 8'h12);
    run_req(1'b0, 1'b1, 8'hFF, 16'h0000, 1'b0);
    run_req(1'b0, 1'b0, 8'hFF, 16'h0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_req(1'b0, 1'b1, 8'h80, 16'h0000, 1'b1);
    run_req(1'b1, 1'b0, 8'h81, 16'h005A, 1'b1);
    run_req(1'b1, 1'b1, 8'h90, 16'h7788, 1'b1);
    run_req(1'b0, 1'b1, 8'h90, 16'h0000, 1'b0);
  endtask

  task automatic test_reset_mid_store();
    logic [7:0] old_hi;
    old_hi    = mem[8'h21];
    req_valid = 1'b1;
    req_write = 1'b1;
    req_wide  = 1'b1;
    req_addr  = 8'h20;
    req_wdata = 16'hCAFE;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_write_enable, mem_address, mem_wdata} !== {1'b1, 8'h20, 8'hFE}) begin
      miscompares++;
      $display("FAIL midrst_byte0: {we,addr,wdata} got %b %02h %02h expected 1 20 fe",
               mem_write_enable, mem_address, mem_wdata);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({mem_read_enable, mem_write_enable} !== 2'b00) begin
      miscompares++;
      $display("FAIL midrst_gate: re/we got %b%b expected 00", mem_read_enable, mem_write_enable);
    end
    ref_mem[8'h20] = 8'hFE;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_no_resp: resp_valid got %b expected 0", resp_valid);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({req_ready, resp_valid, mem_write_enable} !== 3'b100) begin
      miscompares++;
      $display("FAIL midrst_idle: {ready,rvalid,we} got %b%b%b expected 100",
               req_ready, resp_valid, mem_write_enable);
    end
    check_mem("midrst_lo", 8'h20, 8'hFE);
    check_mem("midrst_hi", 8'h21, old_hi);
  endtask

  task automatic test_random();
    logic [7:0] a;
    int         bad;
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      run_req(1'($urandom), 1'($urandom), a, 16'($urandom), 1'($urandom));
    end
    req_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL memory_image: %0d addresses differ from model, expected 0", bad);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wide  = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 16'h0000;
    init_we   = 1'b1;
    init_addr = 8'h00;
    init_data = 8'h00;
    for (int i = 0; i < 256; i++) begin
      init_addr  = 8'(i);
      init_data  = 8'($urandom);
      ref_mem[i] = init_data;
      @(posedge clk);
      #1;
    end
    init_we = 1'b0;
    reset_n = 1'b1;

    test_reset();
    test_byte();
    test_halfword();
    test_wrap();
    test_back_to_back();
    test_reset_mid_store();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer directly upstream of the 256x8 data memory.
- Accepts byte or 16-bit (halfword) load/store requests from the datapath over a valid/ready handshake.
- Splits each halfword into two sequential byte accesses, little-endian.
- Drives the memory's read_enable/write_enable/address/data_in pins and assembles read data into a registered response with a one-cycle valid pulse.

Parameters:
- ADDR_W, 8, memory address width; address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 8, memory byte width; the halfword is 2*DATA_W.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_wide  in  1  1 = halfword (2 bytes), 0 = byte.
- req_addr  in  ADDR_W  byte address of the low byte.
- req_wdata  in  2*DATA_W  store data; [7:0] goes to addr, [15:8] goes to addr+1.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  2*DATA_W  load result; upper byte is 0 for byte loads; 0 for stores.
- resp_wrap  out  1  with resp_valid: halfword access wrapped from address 255 to 0.
- mem_read_enable  out  1  to memory read_enable.
- mem_write_enable  out  1  to memory write_enable.
- mem_address  out  ADDR_W  to memory address.
- mem_wdata  out  DATA_W  to memory data_in.
- mem_rdata  in  DATA_W  from memory data_out (combinational read; high-Z when not enabled).

Behaviour:
- States: IDLE, BYTE0, BYTE1, RESP. Reset state IDLE.
- Reset values:
  - req_ready=1 once in IDLE.
  - resp_valid=0, resp_rdata=0, resp_wrap=0.
  - All mem_* outputs 0.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at the posedge: latch write, wide, addr and wdata; clear the rdata register and wrap flag; go to BYTE0.
  - req_valid=0: stay in IDLE.
- BYTE0:
  - mem_address=addr_r, mem_read_enable=~write_r, mem_write_enable=write_r, mem_wdata=wdata_r[7:0].
  - At the posedge, a load captures mem_rdata into rdata[7:0].
  - Next state is BYTE1 if wide_r, else RESP.
- BYTE1:
  - mem_address=addr_r+1, truncated to ADDR_W, so 255 wraps to 0.
  - mem_wdata=wdata_r[15:8]; enables as in BYTE0.
  - A load captures mem_rdata into rdata[15:8].
  - resp_wrap register set if addr_r==255.
  - Next state RESP.
- RESP:
  - resp_valid=1 for exactly this cycle; resp_rdata and resp_wrap valid.
  - req_ready=0.
  - Next state IDLE.
- Outside BYTE0/BYTE1, all mem_* outputs are 0 (memory sees read_enable=0, so its data_out floats; it is never sampled).
- mem_* outputs are decoded combinationally from state and latched registers only, never from req_* inputs.
- resp_rdata holds its value until the next accepted request clears it.
- Latency from the accept edge T:
  - Byte access: BYTE0 during cycle T+1, resp_valid during T+2.
  - Halfword access: resp_valid during T+3.
  - Next accept possible at the end of the IDLE cycle after RESP, so throughput is one request per 3 (byte) or 4 (halfword) cycles.
- req_* inputs are ignored while req_ready=0; they need not be held after acceptance.
- Reset mid-operation:
  - reset_n=0 forces mem_write_enable and mem_read_enable to 0 combinationally, so no memory write occurs on the reset edge.
  - The in-flight request is dropped with no resp_valid; the state returns to IDLE.
- Store followed by a load of the same address sees the new data, because the memory write lands at the BYTE edge, before the later request's read.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles -> req_ready=1 after release; resp_valid=0; all mem_* outputs 0.
- Byte store then byte load: store addr 0x10, wdata 0x00A5, then load 0x10 -> write_enable high one cycle with address 0x10, data 0xA5; load resp_rdata=0x00A5; resp_valid 2 cycles after each accept.
- Halfword store then halfword load: store 0x40 with 0xBEEF, then load 0x40 -> memory[0x40]=0xEF and memory[0x41]=0xBE; load resp_rdata=0xBEEF, resp_wrap=0, latency 3.
- Wrap-around: halfword store at 0xFF with 0x1234 -> memory[0xFF]=0x34, memory[0x00]=0x12, resp_wrap=1; a halfword load at 0xFF returns 0x1234.
- Backpressure: keep req_valid=1 with changing req_addr while busy -> only the first request is executed; the second is accepted only in the IDLE cycle after RESP.
- Reset mid-store: assert reset_n=0 during the BYTE1 cycle of a halfword store of 0xCAFE to 0x20 -> memory[0x20]=0xFE written, memory[0x21] unchanged, no resp_valid, IDLE after release.
